// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, controller states and defaults for the ALU issue path
package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'd0,
        OP_OR  = 3'd1,
        OP_XOR = 3'd2,
        OP_NOT = 3'd3,
        OP_ADD = 3'd4,
        OP_SUB = 3'd5,
        OP_MUL = 3'd6,
        OP_DIV = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } ctrl_state_e;

    localparam int FIXED_LAT_DEF = 1;
    localparam int TIMEOUT_DEF   = 32;

    function automatic logic is_multicycle(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// rtl/alu_issue_ctrl_if.sv - request, unit-bank and response signals of the ALU issue controller
interface alu_issue_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [7:0]  req_a;
    logic [7:0]  req_b;

    logic        start;
    logic [2:0]  op_sel;
    logic [7:0]  a_out;
    logic [7:0]  b_out;
    logic [15:0] unit_res;
    logic        unit_done;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_res;
    logic        rsp_err;
    logic        busy;

    modport master (
        input  req_valid, req_op, req_a, req_b, unit_res, unit_done, rsp_ready,
        output req_ready, start, op_sel, a_out, b_out, rsp_valid, rsp_res, rsp_err, busy
    );

    modport slave (
        output req_valid, req_op, req_a, req_b, unit_res, unit_done, rsp_ready,
        input  req_ready, start, op_sel, a_out, b_out, rsp_valid, rsp_res, rsp_err, busy
    );

endinterface

// File: rtl/alu_wait_cnt.sv
// rtl/alu_wait_cnt.sv - clearable saturating cycle counter with a reach-terminal flag
module alu_wait_cnt #(
    parameter int MAX = 32,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_cnt,
    output logic         o_hit
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != W'(MAX))) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // High in the enabled cycle whose increment brings the count to MAX (or once saturated).
    assign o_hit = i_en && (r_cnt >= W'(MAX - 1));
    assign o_cnt = r_cnt;

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - accepts one ALU op, pulses start to the unit bank and returns the captured result
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int FIXED_LAT = FIXED_LAT_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    alu_issue_ctrl_if.master bus
);

    localparam int CW = $clog2(TIMEOUT + 1);

    ctrl_state_e   r_state;
    ctrl_state_e   w_state_next;

    logic [2:0]    r_op;
    logic [7:0]    r_a;
    logic [7:0]    r_b;
    logic [15:0]   r_res;
    logic          r_err;

    logic          w_accept;
    logic          w_cnt_clr;
    logic          w_cnt_en;
    logic          w_cap_ok;
    logic          w_cap_err;
    logic [CW-1:0] w_cnt;
    logic          w_cnt_hit;

    alu_wait_cnt #(
        .MAX (TIMEOUT)
    ) u_wait_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_cnt_clr),
        .i_en  (w_cnt_en),
        .o_cnt (w_cnt),
        .o_hit (w_cnt_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_cnt_clr    = 1'b0;
        w_cnt_en     = 1'b0;
        w_cap_ok     = 1'b0;
        w_cap_err    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_cnt_clr    = 1'b1;
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                w_cnt_en = 1'b1;
                if (is_multicycle(r_op)) begin
                    // done is checked first so it wins over a coincident timeout
                    if (bus.unit_done) begin
                        w_cap_ok     = 1'b1;
                        w_state_next = ST_RESP;
                    end else if (w_cnt_hit) begin
                        w_cap_err    = 1'b1;
                        w_state_next = ST_RESP;
                    end
                end else if (w_cnt == CW'(FIXED_LAT - 1)) begin
                    w_cap_ok     = 1'b1;
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op  <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_res <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op <= bus.req_op;
                r_a  <= bus.req_a;
                r_b  <= bus.req_b;
            end
            if (w_cap_ok) begin
                r_res <= bus.unit_res;
                r_err <= 1'b0;
            end else if (w_cap_err) begin
                r_res <= '0;
                r_err <= 1'b1;
            end
        end
    end

    assign bus.req_ready = (r_state == ST_IDLE);
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.start     = (r_state == ST_ISSUE);
    assign bus.rsp_valid = (r_state == ST_RESP);
    assign bus.op_sel    = r_op;
    assign bus.a_out     = r_a;
    assign bus.b_out     = r_b;
    assign bus.rsp_res   = r_res;
    assign bus.rsp_err   = r_err;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - self-checking bench for alu_issue_ctrl with a behavioural unit bank
module tb_alu_issue_ctrl;

    localparam int FIXED_LAT = 1;
    localparam int TIMEOUT   = 32;
    localparam int BOUND     = 80;

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        int          done_at;
        int          stall;
        bit          poke;
        logic [15:0] exp_res;
        logic        exp_err;
        int          exp_cyc;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errs   = 0;
    int   checks = 0;

    alu_issue_ctrl_if bus ();

    alu_issue_ctrl #(
        .FIXED_LAT (FIXED_LAT),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return {8'h00, a & b};
            3'd1:    return {8'h00, a | b};
            3'd2:    return {8'h00, a ^ b};
            3'd3:    return {8'h00, ~a};
            3'd4:    return {8'h00, a} + {8'h00, b};
            3'd5:    return {8'h00, a} - {8'h00, b};
            3'd6:    return {8'h00, a} * {8'h00, b};
            default: return (b == 8'h00) ? 16'hFFFF : ({8'h00, a} / {8'h00, b});
        endcase
    endfunction

    // Unit bank: every unit computes from the registered operands; the mux picks by op_sel.
    assign bus.unit_res = alu_ref(bus.op_sel, bus.a_out, bus.b_out);

    function automatic vec_t model(input vec_t v);
        vec_t m = v;
        if (v.op != 3'd6 && v.op != 3'd7) begin
            m.exp_res = alu_ref(v.op, v.a, v.b);
            m.exp_err = 1'b0;
            m.exp_cyc = 2 + FIXED_LAT;
        end else if (v.done_at >= 1 && v.done_at <= TIMEOUT) begin
            m.exp_res = alu_ref(v.op, v.a, v.b);
            m.exp_err = 1'b0;
            m.exp_cyc = 2 + v.done_at;
        end else begin
            m.exp_res = 16'h0000;
            m.exp_err = 1'b1;
            m.exp_cyc = 2 + TIMEOUT;
        end
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v, output int start_cyc, output int start_cnt, output int rsp_cyc,
                          output logic [15:0] res, output logic err, output bit stable);
        int  resp_n;
        bit  done;
        start_cyc = -1;
        start_cnt = 0;
        rsp_cyc   = -1;
        res       = 16'h0000;
        err       = 1'b0;
        stable    = 1'b1;
        resp_n    = 0;
        done      = 1'b0;
        bus.req_op    = v.op;
        bus.req_a     = v.a;
        bus.req_b     = v.b;
        bus.req_valid = 1'b1;
        bus.rsp_ready = (v.stall == 0);
        tick();
        bus.req_valid = 1'b0;
        for (int cyc = 1; cyc <= BOUND && !done; cyc++) begin
            if (v.poke) begin
                bus.req_valid = 1'b1;
                bus.req_op    = ~v.op;
                bus.req_a     = ~v.a;
                bus.req_b     = ~v.b;
            end
            if (bus.op_sel !== v.op || bus.a_out !== v.a || bus.b_out !== v.b ||
                bus.req_ready !== 1'b0 || bus.busy !== 1'b1)
                stable = 1'b0;
            if (bus.start === 1'b1) begin
                start_cnt++;
                start_cyc = cyc;
            end
            bus.unit_done = (start_cyc >= 1 && cyc == start_cyc + v.done_at);
            if (bus.rsp_valid === 1'b1) begin
                if (rsp_cyc < 0) begin
                    rsp_cyc = cyc;
                    res     = bus.rsp_res;
                    err     = bus.rsp_err;
                end else if (bus.rsp_res !== res || bus.rsp_err !== err) begin
                    stable = 1'b0;
                end
                bus.rsp_ready = (resp_n >= v.stall);
                if (bus.rsp_ready) done = 1'b1;
                resp_n++;
            end
            tick();
        end
        bus.unit_done = 1'b0;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        int          start_cyc;
        int          start_cnt;
        int          rsp_cyc;
        logic [15:0] res;
        logic        err;
        bit          stable;
        run_op(v, start_cyc, start_cnt, rsp_cyc, res, err, stable);
        chk({tag, "_start_cnt"}, start_cnt, 1);
        chk({tag, "_start_cyc"}, start_cyc, 1);
        chk({tag, "_rsp_cyc"}, rsp_cyc, v.exp_cyc);
        chk({tag, "_rsp_res"}, res, v.exp_res);
        chk({tag, "_rsp_err"}, err, v.exp_err);
        chk({tag, "_stable"}, stable, 1);
        chk({tag, "_idle_ready"}, bus.req_ready, 1);
        chk({tag, "_idle_rsp_valid"}, bus.rsp_valid, 0);
        if (rsp_cyc < 0 || bus.req_ready !== 1'b1) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_start"}, bus.start, 0);
        chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        chk({tag, "_rsp_err"}, bus.rsp_err, 0);
        chk({tag, "_rsp_res"}, bus.rsp_res, 0);
        chk({tag, "_a_out"}, bus.a_out, 0);
        chk({tag, "_b_out"}, bus.b_out, 0);
        chk({tag, "_op_sel"}, bus.op_sel, 0);
        chk({tag, "_req_ready"}, bus.req_ready, 1);
        chk({tag, "_busy"}, bus.busy, 0);
    endtask

    initial begin
        vec_t vtab[13];
        bit   quiet;

        vtab[0]  = '{3'd1, 8'hA5, 8'h0F, -1, 0, 1'b0, 16'h00AF, 1'b0, 3};
        vtab[1]  = '{3'd6, 8'h10, 8'h10,  7, 0, 1'b0, 16'h0100, 1'b0, 9};
        vtab[2]  = '{3'd6, 8'h10, 8'h10, -1, 0, 1'b0, 16'h0000, 1'b1, 34};
        vtab[3]  = '{3'd4, 8'hFF, 8'h01, -1, 5, 1'b1, 16'h0100, 1'b0, 3};
        vtab[4]  = '{3'd6, 8'h03, 8'h05, 32, 0, 1'b0, 16'h000F, 1'b0, 34};
        vtab[5]  = '{3'd0, 8'hF0, 8'h3C, -1, 0, 1'b0, 16'h0030, 1'b0, 3};
        vtab[6]  = '{3'd2, 8'hFF, 8'h0F, -1, 1, 1'b0, 16'h00F0, 1'b0, 3};
        vtab[7]  = '{3'd3, 8'h5A, 8'h00, -1, 0, 1'b0, 16'h00A5, 1'b0, 3};
        vtab[8]  = '{3'd5, 8'h05, 8'h07, -1, 0, 1'b0, 16'hFFFE, 1'b0, 3};
        vtab[9]  = '{3'd7, 8'h64, 8'h07,  1, 0, 1'b0, 16'h000E, 1'b0, 3};
        vtab[10] = '{3'd7, 8'h64, 8'h07, 33, 0, 1'b0, 16'h0000, 1'b1, 34};
        vtab[11] = '{3'd6, 8'h02, 8'h02,  0, 0, 1'b0, 16'h0000, 1'b1, 34};
        vtab[12] = '{3'd0, 8'hCC, 8'hAA,  2, 0, 1'b1, 16'h0088, 1'b0, 3};

        bus.req_valid = 1'b0;
        bus.req_op    = 3'd0;
        bus.req_a     = 8'h00;
        bus.req_b     = 8'h00;
        bus.unit_done = 1'b0;
        bus.rsp_ready = 1'b0;

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_reset_vals("por");

        for (int i = 0; i < 13; i++) begin
            apply_vec(vtab[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of a DIV wait, then a stray done that must be ignored.
        bus.req_op    = 3'd7;
        bus.req_a     = 8'h20;
        bus.req_b     = 8'h03;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        tick();
        tick();
        chk("midrst_in_wait", bus.busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_vals("midrst");
        bus.unit_done = 1'b1;
        tick();
        bus.unit_done = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (bus.rsp_valid !== 1'b0 || bus.start !== 1'b0 || bus.req_ready !== 1'b1) quiet = 1'b0;
            tick();
        end
        chk("midrst_late_done_quiet", quiet, 1);
        check_reset_vals("midrst_after");

        for (int n = 0; n < 60; n++) begin
            vec_t v;
            v.op      = 3'($urandom_range(0, 7));
            v.a       = 8'($urandom_range(0, 255));
            v.b       = 8'($urandom_range(0, 255));
            v.done_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(1, 12));
            v.stall   = int'($urandom_range(0, 3));
            v.poke    = 1'($urandom_range(0, 1));
            v         = model(v);
            apply_vec(v, $sformatf("rnd%0d", n));
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Initiator side of the ALU unit interface. Each ALU unit (and/or/xor/not/add/sub, plus the multi-cycle mul/div) samples its operands on the clock edge where start is high and drives a 16-bit res.
- This block accepts one operation request over a valid/ready handshake and drives operands, op select and a one-cycle start pulse to the unit bank.
- It then captures the unit's 16-bit result, after a fixed latency or on done for multi-cycle ops, and returns it over a valid/ready response handshake.
- It sits between the top-level sequencer/testbench driver and the muxed ALU unit bank.

Parameters:
- FIXED_LAT, 1, cycles after the start cycle at whose end unit_res is sampled for single-cycle ops (min 1).
- TIMEOUT, 32, maximum WAIT cycles for a multi-cycle op before an error response.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request (IDLE only)
- req_op  in  3  opcode: 0 AND, 1 OR, 2 XOR, 3 NOT, 4 ADD, 5 SUB, 6 MUL, 7 DIV
- req_a  in  8  operand a
- req_b  in  8  operand b
- start  out  1  one-cycle issue pulse to the selected unit
- op_sel  out  3  selects the unit and result mux
- a_out  out  8  registered operand a to the units
- b_out  out  8  registered operand b to the units
- unit_res  in  16  muxed unit result
- unit_done  in  1  completion strobe from the mul/div units
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_res  out  16  captured result
- rsp_err  out  1  timeout flag for the response
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clocking and reset: single clock. Reset is synchronous and active-high on rst.
- Reset values:
  - state = IDLE; start = 0; rsp_valid = 0; rsp_err = 0.
  - rsp_res = 0; a_out = 0; b_out = 0; op_sel = 0; wait counter = 0.
- States: IDLE, ISSUE, WAIT, RESP. All outputs are registered or decoded from state; there is no combinational path from any input to any output except req_ready/busy, which decode state only.
- IDLE:
  - req_ready = 1.
  - On req_valid: latch req_op, req_a and req_b into op_sel, a_out and b_out, then go to ISSUE.
- ISSUE:
  - start = 1 for exactly this one cycle; the counter is cleared; go to WAIT.
- WAIT, single-cycle ops (op 0-5):
  - The counter increments each cycle.
  - In the FIXED_LAT-th WAIT cycle, sample unit_res into rsp_res, set rsp_err = 0 and go to RESP.
  - unit_done is ignored.
- WAIT, multi-cycle ops (op 6-7):
  - In the first cycle with unit_done = 1, sample unit_res into rsp_res, set rsp_err = 0 and go to RESP.
  - If the counter reaches TIMEOUT without done, set rsp_res = 0, rsp_err = 1 and go to RESP.
  - If done and the timeout occur in the same cycle, done wins.
- RESP:
  - rsp_valid = 1; rsp_res and rsp_err are held stable.
  - On rsp_ready, go to IDLE with rsp_valid dropping on the next cycle.
  - rsp_ready while not in RESP is ignored.
- Operand stability: a_out, b_out and op_sel stay constant from ISSUE until the return to IDLE.
- Latency with FIXED_LAT = 1 and rsp_ready held high:
  - request accepted at the end of cycle 0; start in cycle 1; sample at the end of cycle 2; rsp_valid in cycle 3; back in IDLE in cycle 4.
  - Peak throughput is 1 op per 4 cycles. There is no back-to-back acceptance and no request buffering.
- Width rule: unit_res is passed through as-is (units zero- or sign-extend); this block does no arithmetic on it.
- Reset mid-operation: the in-flight op is discarded and start is forced to 0. A unit_done arriving after reset while in IDLE is ignored.
- Counter width: clog2(TIMEOUT+1) bits. The counter saturates and never wraps.

Decomposition:
- Shared package alu_pkg holds:
  - the opcode enum (OP_AND … OP_DIV);
  - an is_multicycle(op) function;
  - the controller state enum;
  - localparam defaults for FIXED_LAT and TIMEOUT.
- One natural sub-module: alu_wait_cnt, a clearable saturating counter with a terminal-count flag, reused by later multi-cycle units.

Test Plan:
- OR 8'hA5 | 8'h0F, with a model OR unit, rsp_ready = 1 -> start high exactly 1 cycle (cycle 1), rsp_res = 16'h00AF, rsp_err = 0, rsp_valid in cycle 3.
- MUL 8'h10 * 8'h10 with unit_done asserted 7 cycles after start, res = 16'h0100 -> rsp_res = 16'h0100 sampled in the done cycle, rsp_err = 0.
- MUL with unit_done never asserted -> rsp_valid after exactly TIMEOUT = 32 WAIT cycles, rsp_res = 0, rsp_err = 1.
- ADD result held with rsp_ready = 0 for 5 cycles -> rsp_valid, rsp_res and rsp_err stable; req_ready = 0 and a new req_valid is not accepted until one cycle after the rsp_ready handshake.
- rst pulsed during WAIT of DIV, followed by a late unit_done -> all outputs at reset values, no rsp_valid, block in IDLE with req_ready = 1.
- unit_done = 1 on the same cycle the counter hits TIMEOUT -> rsp_err = 0 and rsp_res = unit_res.
